// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one port of the feature-extractor true-dual-port memory
//            (one-cycle read latency) between a read requester and a write
//            requester, with round-robin arbitration when both are valid.
//            Optionally owns a bulk-clear sweep that zeroes every word of the
//            memory between event windows.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Build option:
//   MEM_PORT_ARBITER_CLEAR_EN  defined   -> clear engine and CLEAR state present
//                              undefined -> clr_start ignored, clr_busy/clr_done
//                                           tied low, arbiter is always idle
// ----------------------------------------------------------------------------
// Parameters:
//   AWIDTH  memory address width (clear sweep covers 2**AWIDTH words)
//   DWIDTH  memory data width
// Ports:
//   clk, rst_n          clock (posedge) / asynchronous active-low reset
//   rd_req_valid/ready  read request handshake, rd_req_addr = read address
//   rd_rsp_valid/data   read response, valid two cycles after the handshake
//   wr_req_valid/ready  write request handshake, wr_req_addr/wr_req_data
//   clr_start           single-cycle pulse that starts the bulk clear
//   clr_busy            clear sweep in progress
//   clr_done            one-cycle pulse after the last clear write
//   mem_en/we/addr/din  registered memory port controls
//   mem_dout            memory read data (valid the cycle after a read)
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
  parameter int AWIDTH = 16,
  parameter int DWIDTH = 72
) (
  input  logic              clk,
  input  logic              rst_n,
  // read requester
  input  logic              rd_req_valid,
  output logic              rd_req_ready,
  input  logic [AWIDTH-1:0] rd_req_addr,
  output logic              rd_rsp_valid,
  output logic [DWIDTH-1:0] rd_rsp_data,
  // write requester
  input  logic              wr_req_valid,
  output logic              wr_req_ready,
  input  logic [AWIDTH-1:0] wr_req_addr,
  input  logic [DWIDTH-1:0] wr_req_data,
  // bulk clear control
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              clr_done,
  // memory port pins
  output logic              mem_en,
  output logic              mem_we,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_din,
  input  logic [DWIDTH-1:0] mem_dout
);

  // --------------------------------------------------------------------------
  // Shared declarations
  // --------------------------------------------------------------------------
  logic              w_idle;       // arbiter may grant requests this cycle
  logic              w_clr_go;     // clr_start accepted this cycle
  logic              w_clr_wr;     // a clear write is issued at this edge
  logic [AWIDTH-1:0] w_clr_addr;   // address of that clear write

  logic              w_rd_grant;
  logic              w_wr_grant;
  logic              r_rr_last_wr; // 1: most recent grant went to the writer

  logic              r_mem_en;
  logic              r_mem_we;
  logic [AWIDTH-1:0] r_mem_addr;
  logic [DWIDTH-1:0] r_mem_din;

  // Reads in flight: bit 0 = port cycle, bit 1 = data cycle
  logic [1:0]        r_rd_pipe;

`ifdef MEM_PORT_ARBITER_CLEAR_EN
  // --------------------------------------------------------------------------
  // Clear engine: IDLE <-> CLEAR state machine plus sweep counter
  // --------------------------------------------------------------------------
  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [AWIDTH-1:0] r_clr_cnt;
  logic              r_clr_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_clr_go    = 1'b0;
    w_clr_wr    = 1'b0;
    case (r_state)
      S_IDLE: begin
        // The clear request wins over any pending requester this cycle.
        if (clr_start) begin
          w_clr_go    = 1'b1;
          w_state_nxt = S_CLEAR;
        end
      end
      S_CLEAR: begin
        // One write per cycle; leave once the top address has been issued.
        w_clr_wr = 1'b1;
        if (&r_clr_cnt) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clr_cnt  <= '0;
      r_clr_done <= 1'b0;
    end else begin
      // Pulse lands in the cycle the final clear write is on the port.
      r_clr_done <= w_clr_wr && (&r_clr_cnt);
      if (w_clr_go) begin
        r_clr_cnt <= '0;
      end else if (w_clr_wr) begin
        r_clr_cnt <= r_clr_cnt + 1'b1;
      end
    end
  end

  assign w_idle     = (r_state == S_IDLE);
  assign w_clr_addr = r_clr_cnt;
  assign clr_busy   = (r_state == S_CLEAR);
  assign clr_done   = r_clr_done;
`else
  // --------------------------------------------------------------------------
  // Clear engine absent: permanently idle, clr_start has no effect
  // --------------------------------------------------------------------------
  logic w_unused_clr_start;

  assign w_unused_clr_start = clr_start;
  assign w_idle             = 1'b1;
  assign w_clr_go           = 1'b0;
  assign w_clr_wr           = 1'b0;
  assign w_clr_addr         = '0;
  assign clr_busy           = 1'b0;
  assign clr_done           = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Arbitration. Ready is the grant itself, so at most one ready is high and
  // both are low while reset is asserted, while clearing, and in the cycle a
  // clear is accepted.
  // --------------------------------------------------------------------------
  always_comb begin
    w_rd_grant = 1'b0;
    w_wr_grant = 1'b0;
    if (rst_n && w_idle && !w_clr_go) begin
      if (rd_req_valid && wr_req_valid) begin
        // Contested: the side that did not win last time gets the port.
        if (r_rr_last_wr) begin
          w_rd_grant = 1'b1;
        end else begin
          w_wr_grant = 1'b1;
        end
      end else begin
        w_rd_grant = rd_req_valid;
        w_wr_grant = wr_req_valid;
      end
    end
  end

  assign rd_req_ready = w_rd_grant;
  assign wr_req_ready = w_wr_grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_last_wr <= 1'b1;   // first contested grant goes to the reader
    end else if (w_rd_grant || w_wr_grant) begin
      r_rr_last_wr <= w_wr_grant;
    end
  end

  // --------------------------------------------------------------------------
  // Memory port registers. Address/data hold their last values when idle;
  // only the enables drop back to zero.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_en   <= 1'b0;
      r_mem_we   <= 1'b0;
      r_mem_addr <= '0;
      r_mem_din  <= '0;
    end else begin
      r_mem_en <= 1'b0;
      r_mem_we <= 1'b0;
      if (w_clr_wr) begin
        r_mem_en   <= 1'b1;
        r_mem_we   <= 1'b1;
        r_mem_addr <= w_clr_addr;
        r_mem_din  <= '0;
      end else if (w_wr_grant) begin
        r_mem_en   <= 1'b1;
        r_mem_we   <= 1'b1;
        r_mem_addr <= wr_req_addr;
        r_mem_din  <= wr_req_data;
      end else if (w_rd_grant) begin
        r_mem_en   <= 1'b1;
        r_mem_addr <= rd_req_addr;
      end
    end
  end

  assign mem_en   = r_mem_en;
  assign mem_we   = r_mem_we;
  assign mem_addr = r_mem_addr;
  assign mem_din  = r_mem_din;

  // --------------------------------------------------------------------------
  // Read response tracking. Independent of the FSM so a read accepted just
  // before a clear still returns on schedule; reset drops anything in flight.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_pipe <= 2'b00;
    end else begin
      r_rd_pipe <= {r_rd_pipe[0], w_rd_grant};
    end
  end

  assign rd_rsp_valid = r_rd_pipe[1];
  // Masked so the output is zero whenever no response is being presented.
  assign rd_rsp_data  = r_rd_pipe[1] ? mem_dout : '0;

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one port of the feature-extractor true-dual-port memory (one-cycle read latency, write-or-read per enabled cycle) between a read requester and a write requester.
- Also owns a bulk-clear sweep that zeroes the whole memory between event windows.
- Sits between the graph/feature pipeline stages and the memory port pins: wea, mem_ena, dina, addra, douta.

Parameters:
AWIDTH  16  memory address width; clear sweep covers 2**AWIDTH words
DWIDTH  72  memory data width

Ports:
clk           in   1       clock; all logic on posedge
rst_n         in   1       asynchronous active-low reset
rd_req_valid  in   1       read request valid
rd_req_ready  out  1       read request accepted (combinational)
rd_req_addr   in   AWIDTH  read address
rd_rsp_valid  out  1       read data valid, 1-cycle pulse
rd_rsp_data   out  DWIDTH  read data
wr_req_valid  in   1       write request valid
wr_req_ready  out  1       write request accepted (combinational)
wr_req_addr   in   AWIDTH  write address
wr_req_data   in   DWIDTH  write data
clr_start     in   1       single-cycle pulse: start bulk clear
clr_busy      out  1       clear sweep in progress
clr_done      out  1       1-cycle pulse after last clear write
mem_en        out  1       to memory port enable (registered)
mem_we        out  1       to memory port write enable (registered)
mem_addr      out  AWIDTH  to memory port address (registered)
mem_din       out  DWIDTH  to memory port write data (registered)
mem_dout      in   DWIDTH  from memory port read data

Behaviour:
- Reset: every output low or zero; state IDLE; rr_last = WRITE, so the first contested grant goes to READ.
- Reset asserted mid-sweep aborts the clear: no clr_done pulse, and in-flight read responses are dropped.
- States:
  - IDLE: arbitrates requests.
  - CLEAR: runs the sweep.
- Handshake: a transfer occurs on a posedge where valid and ready are both high. At most one ready is high per cycle. Ready is low in CLEAR, and low in the cycle clr_start is sampled in IDLE.
- Arbitration in IDLE:
  - Only one requester valid: that requester is granted.
  - Both valid: the requester not in rr_last is granted.
  - rr_last updates on every grant.
- Port timing: a handshake at edge T drives the mem_* registers during cycle T+1 with mem_en=1, mem_we = 1 for write / 0 for read. The memory registers data at edge T+1.
- Read response: rd_rsp_valid=1 during cycle T+2, with rd_rsp_data = mem_dout in that cycle. A 2-deep valid shift register tracks reads in flight.
- Throughput: back-to-back grants run one per cycle.
- mem_en=0 whenever no grant or clear write occurs; the data/address registers hold their values.
- clr_start in IDLE: move to CLEAR at the next edge, clr_busy=1, counter=0. No request is granted that cycle.
- CLEAR sweep:
  - Each cycle drives mem_en=1, mem_we=1, mem_addr=counter, mem_din=0; counter increments.
  - After address 2**AWIDTH-1 has been issued: return to IDLE, clr_busy=0, clr_done=1 for one cycle.
  - Sweep length is exactly 2**AWIDTH write cycles, with no wrap or repeat.
- clr_start while in CLEAR is ignored. clr_start in the same cycle as pending requests wins; requests wait, valid held.
- A read accepted before the clear starts still returns its response on schedule, because the response path is independent of state.
- Requesters hold valid/addr/data stable until ready. The arbiter does not buffer requests.
- Write/read to the same address in consecutive grants: the read returns the newly written data, since the memory updates before the later read.

Optional Feature:
- Macro: MEM_PORT_ARBITER_CLEAR_EN.
- Defined: clear engine and CLEAR state present as described.
- Undefined:
  - clr_start ignored; clr_busy and clr_done tied 0.
  - FSM reduces to IDLE only.
  - No sweep counter logic synthesized.

Test Plan:
All tests use AWIDTH=4, DWIDTH=8.
1. Reset, then a single write addr 3 data 0xA5, then a read of addr 3: wr_req_ready high in the request cycle; mem_en=1, mem_we=1 in the following cycle; rd_rsp_valid pulses 2 cycles after the read handshake with data 0xA5.
2. rd and wr both valid continuously for 6 cycles, addresses 1 and 2: grants alternate R,W,R,W,R,W starting with READ; mem_we pattern 0,1,0,1,0,1.
3. Write 0xFF to all 16 addresses, pulse clr_start: clr_busy high for exactly 16 cycles, mem_addr 0..15 with mem_din 0, one clr_done pulse; subsequent reads return 0x00.
4. Hold rd_req_valid during a clear: rd_req_ready stays low throughout; the read is granted in the first IDLE cycle after clr_done and returns 0x00.
5. Deassert rst_n at sweep address 7: all outputs 0 immediately; no clr_done; after release, IDLE with ready behaviour as after a cold reset.
6. Build without MEM_PORT_ARBITER_CLEAR_EN, pulse clr_start with a write pending: clr_busy stays 0, and the write is granted in the same cycle.
